dmem_dma: RTL
=============

# dmem_dma

Block-transfer engine and port arbiter directly upstream of the 256x8 data memory. It owns the memory's single address/write port and multiplexes it between the processor's load/store path and an internal copy/fill engine. The engine moves or initialises a range of words without processor instructions, one access per cycle. The processor is stalled while a transfer is in flight.

## Interface
- W, 8, data width; matches the memory word.
- A, 8, address width; the memory holds 2**A words.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; asserted when 0 at a rising clk edge.
- cpu_write_en  in  1  processor store request.
- cpu_addr  in  A  processor load/store address.
- cpu_data_in  in  W  processor store data.
- cpu_data_out  out  W  load data; always equal to mem_data_out.
- cpu_stall  out  1  high while the engine owns the memory port.
- start  in  1  single-cycle transfer request.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  A  copy source base.
- dst_addr  in  A  destination base.
- length  in  A+1  word count; values above 2**A are treated as 2**A.
- fill_value  in  W  word written in fill mode.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- mem_write_en  out  1  to the memory's write enable.
- mem_addr  out  A  to the memory's address.
- mem_data_in  out  W  to the memory's write data.
- mem_data_out  in  W  combinational read data from the memory.

## Operation
- States: IDLE, RD, WR, FILL, DONE. All are registered; the port mux is combinational from state.
- IDLE/DONE: mem_addr = cpu_addr, mem_write_en = cpu_write_en, mem_data_in = cpu_data_in, cpu_stall = 0.
- start is sampled in IDLE or DONE. On start, src, dst, count, mode and fill_value are latched, and the word index i is cleared.
  - If the clamped count is 0: go to DONE, with no writes.
  - Else if mode = 0: go to RD.
  - Else: go to FILL.
- start is ignored while busy.
- RD: mem_addr = src+i, mem_write_en = 0. mem_data_out is latched into the word buffer. Next state is WR.
- WR: mem_addr = dst+i, mem_write_en = 1, mem_data_in = buffer. Increment i. Next state is RD, or DONE if i+1 = count.
- FILL: mem_addr = dst+i, mem_write_en = 1, mem_data_in = latched fill_value. Increment i. Stay in FILL, or go to DONE when i+1 = count.
- DONE: done = 1 for exactly this cycle, busy = 0. Next state is IDLE, unless start is accepted.
- Address arithmetic is modulo 2**A: src+i and dst+i wrap from 2**A-1 to 0.
- Copy proceeds strictly ascending, one element at a time.
  - An overlapping range with dst in (src, src+count) propagates already-written words. This is defined behaviour, not an error.
- busy = cpu_stall = 1 in RD, WR and FILL. cpu_write_en is ignored in those states.
- start and a CPU access in the same IDLE cycle: the CPU access completes in that cycle, and the engine begins on the next cycle.
- Reset at any point returns to IDLE with i = 0 and the buffer cleared. A partially transferred range stays in memory, and no further engine writes occur.
- While reset = 0: busy = 0, done = 0, cpu_stall = 0, mem_write_en = 0, and mem_addr = cpu_addr.

## Timing
- Start accepted at edge k: busy rises after edge k. The first engine access occurs in cycle k+1.
- Copy of N words occupies 2N cycles (k+1 .. k+2N). done pulses in cycle k+2N+1.
- Fill of N words occupies N cycles. done pulses in cycle k+N+1.
- Length 0: done in cycle k+1, and busy never rises.
- Read latency is zero (combinational memory), so RD captures data at the end of the same cycle.
- A new start accepted during DONE makes busy rise on the following cycle, giving back-to-back transfers with one non-busy cycle between them.

## Configuration
- DMEM_DMA_FILL_EN defined: fill mode is implemented as described.
- DMEM_DMA_FILL_EN undefined:
  - The FILL state, fill_value latch and mode decode are removed.
  - mode and fill_value are ignored, and every transfer is a copy.
  - Port list is unchanged.

## Test plan
- Copy src=0x10, dst=0x80, length=4, source words 0xA1..0xA4: 0x80..0x83 = 0xA1..0xA4; busy high 8 cycles; done in cycle 9.
- Fill dst=0xFE, length=4, fill_value=0x5A: writes land at 0xFE, 0xFF, 0x00, 0x01 (wrap); done in cycle 5; 0x02 unchanged.
- length=0 with start: no mem_write_en pulse; done in cycle k+1; busy stays 0. length=0x1FF fills all 256 words.
- CPU store to 0x40 with data 0x33 issued while busy: not written, and cpu_stall = 1. The same store repeated after done: 0x40 = 0x33.
- Overlapping copy src=0x20, dst=0x21, length=3, with 0x20 = 0x07: 0x21..0x23 all become 0x07.
- Reset asserted after the second WR of a 6-word copy: exactly 2 words written, busy = 0 on the next cycle, no done pulse; a new start then runs normally.

Source files
------------

// File: rtl/dmem_dma.sv
// dmem_dma: copy/fill engine and arbiter in front of the 256x8 data memory.
// Fill mode exists only when DMEM_DMA_FILL_EN is defined; otherwise all transfers copy.
module dmem_dma #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_write_en,
  input  logic [A-1:0] cpu_addr,
  input  logic [W-1:0] cpu_data_in,
  output logic [W-1:0] cpu_data_out,
  output logic         cpu_stall,
  input  logic         start,
  input  logic         mode,
  input  logic [A-1:0] src_addr,
  input  logic [A-1:0] dst_addr,
  input  logic [A:0]   length,
  input  logic [W-1:0] fill_value,
  output logic         busy,
  output logic         done,
  output logic         mem_write_en,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_data_in,
  input  logic [W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
`ifdef DMEM_DMA_FILL_EN
    FILL,
`endif
    DONE
  } state_t;

  localparam logic [A:0] MAXLEN = {1'b1, {A{1'b0}}};
  localparam logic [A:0] ONE    = {{A{1'b0}}, 1'b1};

  state_t       r_state;
  logic [A-1:0] r_src;
  logic [A-1:0] r_dst;
  logic [A:0]   r_cnt;
  logic [A:0]   r_idx;
  logic [W-1:0] r_buf;
`ifdef DMEM_DMA_FILL_EN
  logic [W-1:0] r_fill;
`else
  logic         w_unused_fill;
  assign w_unused_fill = ^{mode, fill_value};
`endif

  logic [A:0]   w_len;
  logic         w_last;
  logic [A-1:0] w_idx;

  assign w_len  = (length > MAXLEN) ? MAXLEN : length;
  assign w_last = (r_idx + ONE) == r_cnt;
  assign w_idx  = r_idx[A-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_buf   <= '0;
`ifdef DMEM_DMA_FILL_EN
      r_fill  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_src <= src_addr;
            r_dst <= dst_addr;
            r_cnt <= w_len;
            r_idx <= '0;
`ifdef DMEM_DMA_FILL_EN
            r_fill <= fill_value;
`endif
            if (w_len == '0) begin
              r_state <= DONE;
            end else begin
`ifdef DMEM_DMA_FILL_EN
              r_state <= mode ? FILL : RD;
`else
              r_state <= RD;
`endif
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RD: begin
          r_buf   <= mem_data_out;
          r_state <= WR;
        end
        WR: begin
          r_idx   <= r_idx + ONE;
          r_state <= w_last ? DONE : RD;
        end
`ifdef DMEM_DMA_FILL_EN
        FILL: begin
          r_idx   <= r_idx + ONE;
          r_state <= w_last ? DONE : FILL;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  // Port mux: CPU owns the memory except in engine states; reset forces it idle.
  always_comb begin
    mem_addr     = cpu_addr;
    mem_write_en = cpu_write_en;
    mem_data_in  = cpu_data_in;
    busy         = 1'b0;
    done         = 1'b0;
    if (!reset) begin
      mem_write_en = 1'b0;
    end else begin
      case (r_state)
        RD: begin
          mem_addr     = r_src + w_idx;
          mem_write_en = 1'b0;
          busy         = 1'b1;
        end
        WR: begin
          mem_addr     = r_dst + w_idx;
          mem_write_en = 1'b1;
          mem_data_in  = r_buf;
          busy         = 1'b1;
        end
`ifdef DMEM_DMA_FILL_EN
        FILL: begin
          mem_addr     = r_dst + w_idx;
          mem_write_en = 1'b1;
          mem_data_in  = r_fill;
          busy         = 1'b1;
        end
`endif
        DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

  assign cpu_stall    = busy;
  assign cpu_data_out = mem_data_out;

endmodule
